// File: rtl/table_stream_reader_pkg.sv
// table_stream_reader_pkg: shared state encoding, record geometry and field offsets for the table stream reader.
package table_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
  localparam int REC_CELLS = 32;
  // Field offsets in PE_WIDTH cells, LSB first: second_margin, first_margin, joint, snp_pair
  localparam int SM_OFF = 0;
  localparam int FM_OFF = 6;
  localparam int JOINT_OFF = 12;
  localparam int SNP_OFF = 30;
  function automatic int rec_width(input int pe);
    return REC_CELLS * pe;
  endfunction
  function automatic int beats(input int pe, input int ow);
    return REC_CELLS * pe / ow;
  endfunction
endpackage

// File: rtl/table_sum_check.sv
// table_sum_check: per-class (case, ctrl) check that joint, first-margin and second-margin totals agree.
module table_sum_check
  import table_stream_reader_pkg::*;
#(
  parameter int PE_WIDTH = 16
) (
  input  logic [18*PE_WIDTH-1:0] joint,
  input  logic [6*PE_WIDTH-1:0]  first_margin,
  input  logic [6*PE_WIDTH-1:0]  second_margin,
  output logic                   bad
);
  localparam int SW = PE_WIDTH + 4;
  logic [SW-1:0] js, fs, ss;
  always_comb begin
    bad = 1'b0;
    js = '0;
    fs = '0;
    ss = '0;
    for (int c = 0; c < 2; c++) begin
      js = '0;
      fs = '0;
      ss = '0;
      for (int i = 0; i < 9; i++) js = js + SW'(joint[(c*9+i)*PE_WIDTH +: PE_WIDTH]);
      for (int i = 0; i < 3; i++) begin
        fs = fs + SW'(first_margin[(c*3+i)*PE_WIDTH +: PE_WIDTH]);
        ss = ss + SW'(second_margin[(c*3+i)*PE_WIDTH +: PE_WIDTH]);
      end
      bad = bad | (js != fs) | (fs != ss);
    end
  end
endmodule

// File: rtl/table_stream_reader.sv
// table_stream_reader: pops one contingency record per handshake and serialises it into OUT_WIDTH stream beats.
// Optional margin consistency check enabled by defining TABLE_SUM_CHECK_EN.
module table_stream_reader
  import table_stream_reader_pkg::*;
#(
  parameter int PE_WIDTH  = 16,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 table_ready,
  output logic                 table_rd_en,
  input  logic                 table_valid_in,
  input  logic [2*PE_WIDTH-1:0]  snp_pair_in,
  input  logic [18*PE_WIDTH-1:0] joint_in,
  input  logic [6*PE_WIDTH-1:0]  first_margin_in,
  input  logic [6*PE_WIDTH-1:0]  second_margin_in,
  input  logic                 upstream_done,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] rec_count,
  output logic                 drained,
  output logic                 proto_err,
  output logic                 check_err
);
  localparam int REC_WIDTH = rec_width(PE_WIDTH);
  localparam int BEATS = beats(PE_WIDTH, OUT_WIDTH);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  state_t state;
  logic [BW-1:0] beat;
  logic [REC_WIDTH-1:0] rec_q;
  // The pop is gated by rst so no record is lost while the block is held in reset
  assign table_rd_en = !rst && state == IDLE && table_ready;
  assign out_valid = state == SEND;
  assign out_data = rec_q[beat*OUT_WIDTH +: OUT_WIDTH];
  assign out_last = out_valid && beat == LAST;
  assign drained = upstream_done && !table_ready && state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      rec_q <= '0;
      rec_count <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | (table_valid_in && state != WAIT);
      case (state)
        IDLE: if (table_ready) state <= WAIT;
        WAIT: if (table_valid_in) begin
          rec_q <= {snp_pair_in, joint_in, first_margin_in, second_margin_in};
          beat <= '0;
          state <= SEND;
        end
        SEND: if (out_ready) begin
          beat <= beat == LAST ? '0 : beat + BW'(1);
          if (beat == LAST) begin
            rec_count <= rec_count + CNT_WIDTH'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TABLE_SUM_CHECK_EN
  logic sum_bad;
  table_sum_check #(.PE_WIDTH(PE_WIDTH)) u_sum_check (
    .joint(rec_q[JOINT_OFF*PE_WIDTH +: 18*PE_WIDTH]),
    .first_margin(rec_q[FM_OFF*PE_WIDTH +: 6*PE_WIDTH]),
    .second_margin(rec_q[SM_OFF*PE_WIDTH +: 6*PE_WIDTH]),
    .bad(sum_bad)
  );
  // Sums come from the captured record, so the flag lands one cycle after capture
  always_ff @(posedge clk) check_err <= !rst && (check_err || (state == SEND && beat == '0 && sum_bad));
`else
  assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_table_stream_reader.sv
// tb_table_stream_reader: randomized record traffic checked every cycle against a transaction-level model.
module tb_table_stream_reader;
  localparam int PE = 16, OW = 64, CW = 32, RW = 512, NB = 8;
  typedef logic [RW-1:0] rec_t;
  logic clk = 1'b0, rst, table_ready, table_rd_en, table_valid_in, upstream_done;
  logic [2*PE-1:0] snp_pair_in;
  logic [18*PE-1:0] joint_in;
  logic [6*PE-1:0] first_margin_in, second_margin_in;
  logic [OW-1:0] out_data;
  logic out_valid, out_last, out_ready, drained, proto_err, check_err;
  logic [CW-1:0] rec_count;
  always #5 clk = ~clk;

  table_stream_reader #(.PE_WIDTH(PE), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .table_ready(table_ready), .table_rd_en(table_rd_en),
    .table_valid_in(table_valid_in), .snp_pair_in(snp_pair_in), .joint_in(joint_in),
    .first_margin_in(first_margin_in), .second_margin_in(second_margin_in),
    .upstream_done(upstream_done), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .rec_count(rec_count), .drained(drained),
    .proto_err(proto_err), .check_err(check_err)
  );

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Cells: second margin 0-5, first margin 6-11, joint 12-29; case class is the lower half of each field
  function automatic bit sums_bad(input rec_t r);
    bit b = 0;
    for (int c = 0; c < 2; c++) begin
      int js = 0, fs = 0, ss = 0;
      for (int i = 0; i < 9; i++) js += int'(r[(12+c*9+i)*16 +: 16]);
      for (int i = 0; i < 3; i++) begin
        fs += int'(r[(6+c*3+i)*16 +: 16]);
        ss += int'(r[(c*3+i)*16 +: 16]);
      end
      if (js != fs || fs != ss) b = 1;
    end
    return b;
  endfunction

  rec_t up_q[$];
  int mode = 0, oc = 0;
  bit stray_req = 0, rd_seen = 0;

  // Upstream FIFO and downstream sink, driven just after each rising edge
  initial begin
    rec_t r;
    table_ready = 0; table_valid_in = 0; out_ready = 1;
    {snp_pair_in, joint_in, first_margin_in, second_margin_in} = '0;
    forever begin
      @(posedge clk); #1;
      table_valid_in = 0;
      if (rd_seen && up_q.size() > 0) begin
        r = up_q.pop_front();
        {snp_pair_in, joint_in, first_margin_in, second_margin_in} = r;
        table_valid_in = 1;
      end else if (stray_req) begin
        {snp_pair_in, joint_in, first_margin_in, second_margin_in} = rand_rec();
        table_valid_in = 1;
      end
      table_ready = up_q.size() != 0;
      oc++;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (oc % 4 == 0 || oc % 4 == 3) : 1'($urandom_range(0, 1));
    end
  end

  bit busy = 0, ev, prev_ev = 0, waiting, exp_proto = 0, exp_chk = 0, chk_bad = 0;
  int cyc = 0, rd_cyc = 0, mk = 0, exp_count = 0, chk_dly = 0;
  int rd_pulses = 0, last_rd = 0, min_gap = 1000, first_v = 0, last_b = 0, beats_seen = 0;
  rec_t cur = '0;

  // Model: a popped record is outstanding until its last beat is accepted; beats leave in order two cycles after the pop
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rd_en_in_reset", table_rd_en, 0);
      busy = 0; mk = 0; exp_count = 0; exp_proto = 0; exp_chk = 0; chk_dly = 0; rd_seen = 0; prev_ev = 0;
    end else begin
      ev = busy && cyc - rd_cyc >= 2;
      chk("out_valid", out_valid, ev);
      chk("rd_en", table_rd_en, table_ready && !busy);
      chk("rec_count", rec_count, exp_count);
      chk("proto_err", proto_err, exp_proto);
      chk("drained", drained, upstream_done && !table_ready && !busy);
      chk("check_err", check_err, exp_chk);
      chk("out_last", out_last, ev && mk == NB - 1);
      if (ev) chk("out_data", out_data, cur[mk*OW +: OW]);
      if (chk_dly > 0) begin
        chk_dly--;
        if (chk_dly == 0) exp_chk |= chk_bad;
      end
      waiting = busy && cyc - rd_cyc == 1;
      if (table_valid_in && !waiting) exp_proto = 1;
      if (table_valid_in && waiting) begin
        cur = {snp_pair_in, joint_in, first_margin_in, second_margin_in};
`ifdef TABLE_SUM_CHECK_EN
        chk_bad = sums_bad(cur);
        chk_dly = 1;
`endif
      end
      if (ev && !prev_ev) first_v = cyc;
      prev_ev = ev;
      if (ev && out_ready) begin
        beats_seen++;
        if (mk == NB - 1) begin
          mk = 0; busy = 0; exp_count++; last_b = cyc;
        end else mk++;
      end
      if (table_rd_en) begin
        if (rd_pulses > 0 && cyc - last_rd < min_gap) min_gap = cyc - last_rd;
        rd_pulses++; last_rd = cyc; busy = 1; rd_cyc = cyc;
      end
      rd_seen = table_rd_en;
    end
    cyc++;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_count(input int tgt);
    int n = 0;
    while (exp_count < tgt && n < 3000) begin step(); n++; end
    chk("wait_records", exp_count >= tgt, 1);
    step();
  endtask

  task automatic clear_stats();
    rd_pulses = 0; min_gap = 1000; beats_seen = 0;
  endtask

  initial begin
    rec_t g, b;
    int n;
    rst = 1; upstream_done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    step();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_rec_count", rec_count, 0);
    chk("reset_proto_err", proto_err, 0);
    chk("reset_check_err", check_err, 0);
    g = '0;
    g[12*16 +: 16] = 5; g[6*16 +: 16] = 5; g[1*16 +: 16] = 5;
    g[21*16 +: 16] = 7; g[9*16 +: 16] = 7; g[5*16 +: 16] = 7;
    g[480 +: 32] = 32'h0003_0007;
    chk("model_sums_good", sums_bad(g), 0);
    up_q.push_back(g);
    wait_count(1);
    chk("check_err_consistent", check_err, 0);
    b = '0;
    b[12*16 +: 16] = 60; b[16*16 +: 16] = 40; b[8*16 +: 16] = 99; b[0 +: 16] = 100;
    chk("model_sums_bad", sums_bad(b), 1);
    up_q.push_back(b);
    wait_count(2);
`ifdef TABLE_SUM_CHECK_EN
    chk("check_err_mismatch", check_err, 1);
`else
    chk("check_err_tied_low", check_err, 0);
`endif
    clear_stats();
    up_q.push_back(rand_rec());
    wait_count(3);
    chk("latency_first_valid", first_v - last_rd, 2);
    chk("latency_last_beat", last_b - last_rd, 9);
    chk("single_rd_pulse", rd_pulses, 1);
    chk("count_after_single", rec_count, 3);
    mode = 1;
    clear_stats();
    up_q.push_back(rand_rec());
    wait_count(4);
    chk("backpressure_beats", beats_seen, 8);
    chk("count_after_backpressure", rec_count, 4);
    mode = 0;
    clear_stats();
    repeat (3) up_q.push_back(rand_rec());
    wait_count(7);
    chk("queued_rd_pulses", rd_pulses, 3);
    chk("queued_rd_gap", min_gap >= 10, 1);
    chk("queued_beats", beats_seen, 24);
    chk("count_after_queued", rec_count, 7);
    stray_req = 1;
    step();
    stray_req = 0;
    step();
    step();
    chk("stray_proto_err", proto_err, 1);
    chk("stray_no_valid", out_valid, 0);
    chk("stray_count", rec_count, 7);
    mode = 2;
    for (int i = 0; i < 20; i++) begin
      up_q.push_back(rand_rec());
      repeat ($urandom_range(0, 12)) step();
    end
    wait_count(27);
    chk("count_after_random", rec_count, 27);
    mode = 0;
    up_q.push_back(rand_rec());
    n = 0;
    while (!(busy && mk == 4) && n < 100) begin step(); n++; end
    chk("reached_beat4", busy && mk == 4, 1);
    @(posedge clk); #1;
    rst = 1; upstream_done = 1;
    @(posedge clk); #1;
    rst = 0;
    step();
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_rec_count", rec_count, 0);
    chk("midreset_drained", drained, 1);
    chk("midreset_proto_err", proto_err, 0);
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
